// File: rtl/hv_owt_tx_ctrl.sv
// hv_owt_tx_ctrl -- one-wire Manchester frame transmitter.
//
// Sends one frame per accepted request:
//   sync head (OWT_SYNC_BIT_NUM Manchester zeros), sync tail (1,1,0,0),
//   cmd byte, data byte (left out for the short read frame cmd == 8'h1F),
//   CRC-8 (poly 0x07, init 0x00) over cmd[+data], end tail (1,1,0,0),
//   then OWT_GAP_HALF_NUM idle-low half-bits before the next request can be taken.
// Each half-bit lasts OWT_EXT_CYC_NUM clock cycles. Manchester zero is low->high
// and Manchester one is high->low.
//
// Ports:
//   i_clk          block clock, rising edge
//   i_rst          synchronous active-high reset
//   i_tx_vld       frame request
//   o_tx_rdy       request accepted when high together with i_tx_vld
//   i_tx_cmd       command byte (bit7 = 1 write, 0 read)
//   i_tx_data      data byte
//   o_hv_lv_owt_tx registered one-wire line
//   o_tx_busy      frame or gap in progress
//   o_tx_done      one-cycle pulse when the end tail completes
module hv_owt_tx_ctrl #(
    parameter int OWT_EXT_CYC_NUM  = 4,
    parameter int OWT_SYNC_BIT_NUM = 12,
    parameter int OWT_GAP_HALF_NUM = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_tx_vld,
    output logic       o_tx_rdy,
    input  logic [7:0] i_tx_cmd,
    input  logic [7:0] i_tx_data,
    output logic       o_hv_lv_owt_tx,
    output logic       o_tx_busy,
    output logic       o_tx_done
);

    localparam int CYC_W  = (OWT_EXT_CYC_NUM > 1) ? $clog2(OWT_EXT_CYC_NUM) : 1;
    localparam int HALF_W = 16;
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(OWT_EXT_CYC_NUM - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SYNC_HEAD = 3'd1,
        SYNC_TAIL = 3'd2,
        CMD       = 3'd3,
        DATA      = 3'd4,
        CRC       = 3'd5,
        END_TAIL  = 3'd6,
        GAP       = 3'd7
    } state_t;

    state_t              state, state_n;
    logic [CYC_W-1:0]    cyc_cnt, cyc_cnt_n;
    logic [HALF_W-1:0]   half_cnt, half_cnt_n;
    logic [7:0]          cmd_q, cmd_n;
    logic [7:0]          data_q, data_n;
    logic [7:0]          crc_q, crc_n;
    logic                line_q, line_n;
    logic                done_q, done_n;

    // CRC-8, poly 0x07, MSB first, folded over one byte.
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc_in, input logic [7:0] b);
        logic [7:0] c;
        logic       fb;
        c = crc_in;
        for (int i = 7; i >= 0; i--) begin
            fb = c[7] ^ b[i];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    function automatic logic is_short(input logic [7:0] c);
        return (c[7] == 1'b0) && (c[6:0] == 7'h1F);
    endfunction

    // Index of the last half-bit of each state.
    function automatic logic [HALF_W-1:0] half_last(input state_t s);
        case (s)
            SYNC_HEAD:          return HALF_W'(2 * OWT_SYNC_BIT_NUM - 1);
            SYNC_TAIL, END_TAIL: return HALF_W'(3);
            CMD, DATA, CRC:     return HALF_W'(15);
            GAP:                return HALF_W'(OWT_GAP_HALF_NUM - 1);
            default:            return '0;
        endcase
    endfunction

    // Line level for a given half-bit. For a Manchester bit b the first half
    // is b and the second half is ~b, i.e. level = b ^ phase.
    function automatic logic half_level(input state_t s, input logic [HALF_W-1:0] h,
                                        input logic [7:0] c, input logic [7:0] d,
                                        input logic [7:0] r);
        logic [2:0] idx;
        idx = 3'd7 - h[3:1];
        case (s)
            SYNC_HEAD:           return h[0];
            SYNC_TAIL, END_TAIL: return ~h[1];
            CMD:                 return c[idx] ^ h[0];
            DATA:                return d[idx] ^ h[0];
            CRC:                 return r[idx] ^ h[0];
            default:             return 1'b0;
        endcase
    endfunction

    function automatic state_t state_after(input state_t s, input logic [7:0] c);
        case (s)
            SYNC_HEAD: return SYNC_TAIL;
            SYNC_TAIL: return CMD;
            CMD:       return is_short(c) ? CRC : DATA;
            DATA:      return CRC;
            CRC:       return END_TAIL;
            END_TAIL:  return GAP;
            default:   return IDLE;
        endcase
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            cyc_cnt  <= '0;
            half_cnt <= '0;
            cmd_q    <= 8'h00;
            data_q   <= 8'h00;
            crc_q    <= 8'h00;
            line_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_n;
            cyc_cnt  <= cyc_cnt_n;
            half_cnt <= half_cnt_n;
            cmd_q    <= cmd_n;
            data_q   <= data_n;
            crc_q    <= crc_n;
            line_q   <= line_n;
            done_q   <= done_n;
        end
    end

    always_comb begin
        state_n    = state;
        cyc_cnt_n  = cyc_cnt;
        half_cnt_n = half_cnt;
        cmd_n      = cmd_q;
        data_n     = data_q;
        crc_n      = crc_q;
        done_n     = 1'b0;

        if (state == IDLE) begin
            cyc_cnt_n  = '0;
            half_cnt_n = '0;
            if (i_tx_vld) begin
                state_n = SYNC_HEAD;
                cmd_n   = i_tx_cmd;
                data_n  = i_tx_data;
                // The whole CRC is known at acceptance, so it is computed once here.
                crc_n   = is_short(i_tx_cmd) ? crc8_byte(8'h00, i_tx_cmd)
                                             : crc8_byte(crc8_byte(8'h00, i_tx_cmd), i_tx_data);
            end
        end else if (cyc_cnt == CYC_LAST) begin
            cyc_cnt_n = '0;
            if (half_cnt == half_last(state)) begin
                half_cnt_n = '0;
                state_n    = state_after(state, cmd_q);
                done_n     = (state == END_TAIL);
            end else begin
                half_cnt_n = half_cnt + 1'b1;
            end
        end else begin
            cyc_cnt_n = cyc_cnt + 1'b1;
        end

        // The line register is loaded with the level of the half-bit that starts
        // next cycle, so state changes never leave a one-cycle bubble.
        line_n = half_level(state_n, half_cnt_n, cmd_n, data_n, crc_n);
    end

    assign o_hv_lv_owt_tx = line_q;
    assign o_tx_done      = done_q;
    assign o_tx_busy      = (state != IDLE);
    assign o_tx_rdy       = (state == IDLE) && !i_rst;

endmodule

// File: doc/hv_owt_tx_ctrl.md
HV_OWT_TX_CTRL -- requirements
Module: hv_owt_tx_ctrl

Interface
REQ-001 SHALL have parameter OWT_EXT_CYC_NUM, default 4, clock cycles per Manchester half-bit.
REQ-002 SHALL have parameter OWT_SYNC_BIT_NUM, default 12, Manchester-zero bits in sync head.
REQ-003 SHALL have parameter OWT_GAP_HALF_NUM, default 4, idle-low half-bits enforced after each frame.
REQ-004 SHALL have fixed field widths: cmd 8, data 8, CRC 8, tail 4 half-bits.
REQ-005 SHALL have port i_clk, input, 1, single block clock; all logic on its rising edge.
REQ-006 SHALL have port i_rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port i_tx_vld, input, 1, frame request.
REQ-008 SHALL have port o_tx_rdy, output, 1, block can accept a frame.
REQ-009 SHALL have port i_tx_cmd, input, 8, command byte; bit7 = 1 for write, 0 for read.
REQ-010 SHALL have port i_tx_data, input, 8, data byte.
REQ-011 SHALL have port o_hv_lv_owt_tx, output, 1, registered one-wire line.
REQ-012 SHALL have port o_tx_busy, output, 1, frame or gap in progress.
REQ-013 SHALL have port o_tx_done, output, 1, one-cycle pulse at end-tail completion.

Function
REQ-014 SHALL accept a frame on the cycle i_tx_vld & o_tx_rdy are both high and latch i_tx_cmd/i_tx_data at that cycle; later input changes SHALL be ignored.
REQ-015 SHALL drive o_tx_rdy = 1 only in IDLE, and only when i_rst is low.
REQ-016 SHALL implement FSM states IDLE, SYNC_HEAD, SYNC_TAIL, CMD, DATA, CRC, END_TAIL, GAP.
REQ-017 SHALL take IDLE->SYNC_HEAD on acceptance, and drive the first half-bit on o_hv_lv_owt_tx in the cycle after acceptance.
REQ-018 SHALL hold every half-bit level for exactly OWT_EXT_CYC_NUM cycles, using a half-bit cycle counter that wraps at OWT_EXT_CYC_NUM-1.
REQ-019 SHALL encode Manchester zero as low then high, and Manchester one as high then low.
REQ-020 SHALL in SYNC_HEAD send OWT_SYNC_BIT_NUM Manchester zeros, then go to SYNC_TAIL.
REQ-021 SHALL in SYNC_TAIL send raw half-bit levels 1,1,0,0, then go to CMD.
REQ-022 SHALL in CMD send the cmd byte MSB first.
REQ-023 SHALL at the end of CMD go to CRC, skipping DATA, when cmd[7]==0 and cmd[6:0]==7'h1F (short read frame); otherwise it SHALL go to DATA.
REQ-024 SHALL in DATA send the data byte MSB first, then go to CRC.
REQ-025 SHALL compute CRC as CRC-8, polynomial 0x07, init 0x00, no reflection, no final XOR, over the transmitted cmd bits then data bits (data omitted in short frames), MSB first.
REQ-026 SHALL in CRC send the 8-bit CRC MSB first, then go to END_TAIL.
REQ-027 SHALL in END_TAIL send raw half-bit levels 1,1,0,0, then go to GAP.
REQ-028 SHALL pulse o_tx_done for 1 cycle on the END_TAIL->GAP transition.
REQ-029 SHALL in GAP drive the line low for OWT_GAP_HALF_NUM half-bits, then go to IDLE; i_tx_vld during GAP SHALL be ignored, not queued.
REQ-030 SHALL drive the line low in IDLE.
REQ-031 SHALL drive o_tx_busy = 1 in every state except IDLE.
REQ-032 SHALL make the full frame 80 half-bits (320 cycles) and the short frame 64 half-bits (256 cycles) at default parameters, excluding GAP.
REQ-033 SHALL use bit counters that reset to 0 on every state transition and wrap only via the transition.
REQ-034 SHALL drive each state's first half-bit in the cycle immediately after the previous state's last half-bit ends (no bubble).

Reset
REQ-035 SHALL, while i_rst = 1 at a clock edge, force next cycle: state IDLE, all counters 0, CRC 0x00, latched cmd/data 0x00, o_hv_lv_owt_tx = 0, o_tx_busy = 0, o_tx_done = 0, o_tx_rdy = 0.
REQ-036 SHALL, on reset asserted mid-frame, abort the frame with no o_tx_done pulse and no GAP, and assert o_tx_rdy in the first cycle after i_rst falls.

Verification
REQ-037 SHALL be checked with: accept cmd 0x80, data 0x00 -> 320-cycle frame; decoded cmd 0x80, data 0x00, CRC 0xB6; o_tx_done at cycle 320 after acceptance.
REQ-038 SHALL be checked with: accept cmd 0x1F -> no DATA field, CRC 0x5D, o_tx_done at cycle 256, line low afterward.
REQ-039 SHALL be checked with: cmd 0x00, data 0x00 -> CRC 0x00; sync head is 12 low/high pairs, each level exactly 4 cycles, followed by tail 1,1,0,0.
REQ-040 SHALL be checked with: i_tx_vld held high continuously -> second frame's first half-bit starts exactly 16 cycles of GAP plus 1 acceptance cycle after o_tx_done; inputs changed mid-frame do not alter the transmitted bits.
REQ-041 SHALL be checked with: i_rst pulsed during DATA -> line 0 and busy 0 the next cycle, no done pulse, o_tx_rdy = 1 one cycle after reset release.
REQ-042 SHALL be checked with: loopback through the receiver using OWT_EXT_CYC_NUM = 4 -> receiver reports status 0 and matching cmd/data/CRC for 100 random frames.
